// File: rtl/write_accounter_if.sv
// Bank-write observation and read-lookup bundle for write_accounter.
// The master side is the memory fabric; the slave side is the live-value table.
interface write_accounter_if #(
  parameter int ADDR_WIDTH   = 8,
  parameter int NB_WRAGENT   = 2,
  parameter int NB_RDAGENT   = 2,
  parameter int SELECT_WIDTH = (NB_WRAGENT == 1) ? 1 : $clog2(NB_WRAGENT)
);
  logic [NB_WRAGENT-1:0]              wren;
  logic [NB_WRAGENT*ADDR_WIDTH-1:0]   wraddr;
  logic [NB_RDAGENT-1:0]              rden;
  logic [NB_RDAGENT*ADDR_WIDTH-1:0]   rdaddr;
  logic [NB_RDAGENT*SELECT_WIDTH-1:0] rdselect;

  modport master (
    output wren, wraddr, rden, rdaddr,
    input  rdselect
  );

  modport slave (
    input  wren, wraddr, rden, rdaddr,
    output rdselect
  );
endinterface

// File: rtl/write_accounter.sv
// Live-value table: remembers which write bank last wrote each address and tells read agents.
// Optional saturating collision counter enabled by macro WRACC_COLLISION_CNT_EN.
module write_accounter #(
  parameter int ADDR_WIDTH   = 8,
  parameter int NB_WRAGENT   = 2,
  parameter int NB_RDAGENT   = 2,
  parameter int SELECT_WIDTH = (NB_WRAGENT == 1) ? 1 : $clog2(NB_WRAGENT),
  parameter int CNT_WIDTH    = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  write_accounter_if.slave bus,
  output logic             wrcollide
`ifdef WRACC_COLLISION_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] collide_cnt
`endif
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic collide;

  // Read enables do not influence the lookup or the collision flag.
  wire unused_rden = &{1'b0, bus.rden};

  generate
    if (NB_WRAGENT > 1) begin : g_table
      logic [SELECT_WIDTH-1:0] entry_q [DEPTH];

      always_comb begin
        collide = 1'b0;
        for (int i = 0; i < NB_WRAGENT; i++) begin
          for (int k = i + 1; k < NB_WRAGENT; k++) begin
            if (bus.wren[i] && bus.wren[k] &&
                (bus.wraddr[ADDR_WIDTH*i +: ADDR_WIDTH] == bus.wraddr[ADDR_WIDTH*k +: ADDR_WIDTH]))
              collide = 1'b1;
          end
        end
      end

      // Ascending loop order makes the highest agent index win on a shared address.
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          for (int d = 0; d < DEPTH; d++) entry_q[d] <= '0;
          wrcollide <= 1'b0;
        end else begin
          for (int i = 0; i < NB_WRAGENT; i++) begin
            if (bus.wren[i])
              entry_q[bus.wraddr[ADDR_WIDTH*i +: ADDR_WIDTH]] <= SELECT_WIDTH'(i);
          end
          wrcollide <= collide;
        end
      end

      // No write bypass: a same-cycle write shows up only after the edge.
      always_comb begin
        bus.rdselect = '0;
        for (int j = 0; j < NB_RDAGENT; j++)
          bus.rdselect[SELECT_WIDTH*j +: SELECT_WIDTH] =
            entry_q[bus.rdaddr[ADDR_WIDTH*j +: ADDR_WIDTH]];
      end
    end else begin : g_single
      // A single bank is always live; no table storage is needed.
      wire unused_single = &{1'b0, bus.wren, bus.wraddr, bus.rdaddr};
      assign collide      = 1'b0;
      assign wrcollide    = 1'b0;
      assign bus.rdselect = '0;
    end
  endgenerate

`ifdef WRACC_COLLISION_CNT_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)
      collide_cnt <= '0;
    else if (collide && (collide_cnt != {CNT_WIDTH{1'b1}}))
      collide_cnt <= collide_cnt + CNT_WIDTH'(1);
  end
`else
  localparam int unused_cnt_width = CNT_WIDTH;
`endif
endmodule

// File: tb/tb_write_accounter.sv
// Directed bench for write_accounter: vector table plus reset and saturation sequences.
// Define WRACC_COLLISION_CNT_EN to also check the collision counter (built with CNT_WIDTH=2).
module tb_write_accounter;
  localparam int CNT_W = 2;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic wrcollide;
`ifdef WRACC_COLLISION_CNT_EN
  logic [CNT_W-1:0] collide_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 aclk = ~aclk;

  write_accounter_if #(.ADDR_WIDTH(8), .NB_WRAGENT(2), .NB_RDAGENT(2)) bus ();

  write_accounter #(
    .ADDR_WIDTH(8), .NB_WRAGENT(2), .NB_RDAGENT(2), .CNT_WIDTH(CNT_W)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .bus         (bus),
    .wrcollide   (wrcollide)
`ifdef WRACC_COLLISION_CNT_EN
    ,
    .collide_cnt (collide_cnt)
`endif
  );

  typedef struct {
    logic [1:0] wren;
    logic [7:0] wa0;
    logic [7:0] wa1;
    logic [7:0] ra0;
    logic [7:0] ra1;
    logic       s0;
    logic       s1;
    logic       col;
    logic [1:0] cnt;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] wren, input logic [7:0] wa0, input logic [7:0] wa1,
                       input logic [7:0] ra0, input logic [7:0] ra1);
    bus.wren   = wren;
    bus.wraddr = {wa1, wa0};
    bus.rden   = 2'b11;
    bus.rdaddr = {ra1, ra0};
  endtask

  task automatic check_cnt(input string name, input logic [1:0] exp);
`ifdef WRACC_COLLISION_CNT_EN
    check(name, 32'(collide_cnt), 32'(exp));
`endif
  endtask

  initial begin
    //          wren   wa0    wa1    ra0    ra1   s0    s1    col   cnt
    vecs[0]  = '{2'b00, 8'h00, 8'h00, 8'h10, 8'hFF, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[1]  = '{2'b10, 8'h00, 8'h10, 8'h10, 8'h10, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[2]  = '{2'b00, 8'h00, 8'h00, 8'h10, 8'h11, 1'b1, 1'b0, 1'b0, 2'd0};
    vecs[3]  = '{2'b11, 8'h20, 8'h20, 8'h20, 8'h10, 1'b0, 1'b1, 1'b0, 2'd0};
    vecs[4]  = '{2'b00, 8'h00, 8'h00, 8'h20, 8'h20, 1'b1, 1'b1, 1'b1, 2'd1};
    vecs[5]  = '{2'b11, 8'h30, 8'h31, 8'h30, 8'h31, 1'b0, 1'b0, 1'b0, 2'd1};
    vecs[6]  = '{2'b00, 8'h00, 8'h00, 8'h30, 8'h31, 1'b0, 1'b1, 1'b0, 2'd1};
    vecs[7]  = '{2'b01, 8'h10, 8'h00, 8'h10, 8'h20, 1'b1, 1'b1, 1'b0, 2'd1};
    vecs[8]  = '{2'b00, 8'h00, 8'h00, 8'h10, 8'h31, 1'b0, 1'b1, 1'b0, 2'd1};
    vecs[9]  = '{2'b11, 8'h55, 8'h55, 8'h55, 8'h55, 1'b0, 1'b0, 1'b0, 2'd1};
    vecs[10] = '{2'b11, 8'h55, 8'h55, 8'h55, 8'h55, 1'b1, 1'b1, 1'b1, 2'd2};
    vecs[11] = '{2'b00, 8'h00, 8'h00, 8'h55, 8'h00, 1'b1, 1'b0, 1'b1, 2'd3};
    vecs[12] = '{2'b00, 8'h00, 8'h00, 8'h20, 8'h30, 1'b1, 1'b0, 1'b0, 2'd3};
    vecs[13] = '{2'b10, 8'h00, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 2'd3};
    vecs[14] = '{2'b00, 8'h00, 8'h00, 8'hFF, 8'h31, 1'b1, 1'b1, 1'b0, 2'd3};

    drive(2'b00, 8'h00, 8'h00, 8'h10, 8'hFF);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    #2;
    check("reset_wrcollide", 32'(wrcollide), 32'd0);
    check_cnt("reset_cnt", 2'd0);

    for (int v = 0; v < 15; v++) begin
      @(negedge aclk);
      drive(vecs[v].wren, vecs[v].wa0, vecs[v].wa1, vecs[v].ra0, vecs[v].ra1);
      #2;
      check($sformatf("vec%0d_sel0", v), 32'(bus.rdselect[0]), 32'(vecs[v].s0));
      check($sformatf("vec%0d_sel1", v), 32'(bus.rdselect[1]), 32'(vecs[v].s1));
      check($sformatf("vec%0d_wrcollide", v), 32'(wrcollide), 32'(vecs[v].col));
      check_cnt($sformatf("vec%0d_cnt", v), vecs[v].cnt);
    end

    // Asynchronous reset in the middle of traffic
    @(negedge aclk);
    drive(2'b11, 8'h40, 8'h40, 8'h40, 8'h31);
    @(negedge aclk);
    drive(2'b00, 8'h00, 8'h00, 8'h40, 8'h31);
    #2;
    check("prerst_sel0", 32'(bus.rdselect[0]), 32'd1);
    check("prerst_sel1", 32'(bus.rdselect[1]), 32'd1);
    check("prerst_wrcollide", 32'(wrcollide), 32'd1);
    #1;
    aresetn = 1'b0;
    #1;
    check("rst_sel0", 32'(bus.rdselect[0]), 32'd0);
    check("rst_sel1", 32'(bus.rdselect[1]), 32'd0);
    check("rst_wrcollide", 32'(wrcollide), 32'd0);
    check_cnt("rst_cnt", 2'd0);
    drive(2'b10, 8'h00, 8'h41, 8'h41, 8'h40);
    @(negedge aclk);
    aresetn = 1'b1;
    #2;
    check("rst_write_ignored", 32'(bus.rdselect[0]), 32'd0);
    @(negedge aclk);
    drive(2'b00, 8'h00, 8'h00, 8'h41, 8'h40);
    #2;
    check("post_release_write", 32'(bus.rdselect[0]), 32'd1);
    check("post_release_other", 32'(bus.rdselect[1]), 32'd0);

    // Five back-to-back colliding cycles; counter saturates at all-ones
    for (int c = 0; c < 5; c++) begin
      @(negedge aclk);
      drive(2'b11, 8'h77, 8'h77, 8'h77, 8'h41);
    end
    @(negedge aclk);
    drive(2'b00, 8'h00, 8'h00, 8'h77, 8'h41);
    #2;
    check("sat_wrcollide", 32'(wrcollide), 32'd1);
    check("sat_sel0", 32'(bus.rdselect[0]), 32'd1);
    check_cnt("sat_cnt", 2'd3);
    @(negedge aclk);
    #2;
    check("sat_wrcollide_clear", 32'(wrcollide), 32'd0);
    check_cnt("sat_cnt_hold", 2'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
